lcd_frame_sequencer: RTL

Top-level sequencer for the ILI9341 path. It drives the panel hardware-reset pin and triggers the command-array sender: first the init array, then the window-set (loop) array before each frame. Between windows it gates the pixel streamer for exactly one frame of pixels. It sits above the command sender and pixel streamer and arbitrates the shared SPI shifter between them, so only one of them is enabled at a time.

---
 rtl/lcd_frame_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lcd_frame_sequencer.sv
// ILI9341 frame sequencer: panel reset, init/window command arrays, one-frame pixel gating.
// Owns the shared SPI shifter arbitration between command sender and pixel streamer.
module lcd_frame_sequencer #(
    parameter int RST_LOW_CYC     = 10000,
    parameter int RST_WAIT_CYC    = 600000,
    parameter int SLPOUT_WAIT_CYC = 6000000,
    parameter int PIXELS          = 76800,
    parameter int TIMEOUT_CYC     = 1000000,
    parameter int FCW             = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_frame_req,
    input  logic                        i_comm_array_sent,
    input  logic                        i_pixel_sent,
    output logic                        o_lcd_rst_n,
    output logic                        o_send_comm_ena,
    output logic                        o_command,
    output logic                        o_pixel_ena,
    output logic [$clog2(PIXELS+1)-1:0] o_pixel_cnt,
    output logic                        o_frame_done,
    output logic [FCW-1:0]              o_frame_cnt,
    output logic                        o_ready,
    output logic                        o_error
);
    localparam int PCW  = $clog2(PIXELS + 1);
    localparam int M1   = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int M2   = (SLPOUT_WAIT_CYC > TIMEOUT_CYC) ? SLPOUT_WAIT_CYC : TIMEOUT_CYC;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXC + 1);

    // Terminal counts: the shared counter runs 0..N-1 so each state lasts exactly N cycles.
    localparam logic [CW-1:0]  LOW_TC  = CW'(RST_LOW_CYC - 1);
    localparam logic [CW-1:0]  WAIT_TC = CW'(RST_WAIT_CYC - 1);
    localparam logic [CW-1:0]  SLP_TC  = CW'(SLPOUT_WAIT_CYC - 1);
    localparam logic [CW-1:0]  TO_TC   = CW'(TIMEOUT_CYC - 1);
    localparam logic [PCW-1:0] PIX_TC  = PCW'(PIXELS - 1);

    typedef enum logic [3:0] {
        HW_RST, RST_WAIT, INIT_REQ, INIT_RUN, INIT_WAIT, READY,
        WIN_REQ, WIN_RUN, PIX, FDONE, ERROR
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           pend_q, pend_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HW_RST;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            fcnt_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            fcnt_q  <= fcnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = '0;
        pcnt_d          = pcnt_q;
        fcnt_d          = fcnt_q;
        pend_d          = pend_q;
        o_lcd_rst_n     = 1'b1;
        o_send_comm_ena = 1'b0;
        o_command       = 1'b0;
        o_pixel_ena     = 1'b0;
        o_frame_done    = 1'b0;
        o_ready         = 1'b0;
        o_error         = 1'b0;

        // Requests during a frame are remembered one deep; earlier ones are dropped.
        if (i_frame_req && (state_q inside {WIN_REQ, WIN_RUN, PIX, FDONE}))
            pend_d = 1'b1;

        case (state_q)
            HW_RST: begin
                o_lcd_rst_n = 1'b0;
                if (cnt_q == LOW_TC) state_d = RST_WAIT;
                else                 cnt_d   = cnt_q + CW'(1);
            end
            RST_WAIT: begin
                if (cnt_q == WAIT_TC) state_d = INIT_REQ;
                else                  cnt_d   = cnt_q + CW'(1);
            end
            INIT_REQ: begin
                o_send_comm_ena = 1'b1;
                state_d         = INIT_RUN;
            end
            INIT_RUN: begin
                // A strobe on the last allowed cycle beats the timeout.
                if (i_comm_array_sent)  state_d = INIT_WAIT;
                else if (cnt_q == TO_TC) state_d = ERROR;
                else                     cnt_d   = cnt_q + CW'(1);
            end
            INIT_WAIT: begin
                if (cnt_q == SLP_TC) state_d = READY;
                else                 cnt_d   = cnt_q + CW'(1);
            end
            READY: begin
                o_ready = 1'b1;
                if (i_frame_req || pend_q) begin
                    pend_d  = 1'b0;
                    state_d = WIN_REQ;
                end
            end
            WIN_REQ: begin
                o_send_comm_ena = 1'b1;
                o_command       = 1'b1;
                state_d         = WIN_RUN;
            end
            WIN_RUN: begin
                o_command = 1'b1;
                if (i_comm_array_sent)  state_d = PIX;
                else if (cnt_q == TO_TC) state_d = ERROR;
                else                     cnt_d   = cnt_q + CW'(1);
            end
            PIX: begin
                o_pixel_ena = 1'b1;
                if (i_pixel_sent) begin
                    pcnt_d = pcnt_q + PCW'(1);
                    if (pcnt_q == PIX_TC) state_d = FDONE;
                end
            end
            FDONE: begin
                o_frame_done = 1'b1;
                fcnt_d       = fcnt_q + FCW'(1);
                pcnt_d       = '0;
                state_d      = READY;
            end
            ERROR: begin
                o_error = 1'b1;
            end
            default: state_d = ERROR;
        endcase
    end

    assign o_pixel_cnt = pcnt_q;
    assign o_frame_cnt = fcnt_q;
endmodule
